// File: rtl/mips_ifetch.sv
// MIPS instruction-fetch stage: PC register, request/ack fetch FSM and next-PC selection.
// Optional IFETCH_PERF_EN macro adds retired-instruction and fetch-stall counters.
//
// state    | meaning
// ST_RESET | held in reset; PC = RESET_PC, no request
// ST_FETCH | imem_req high at pc, waiting for imem_ack
// ST_EXEC  | instruction valid, waiting for exec_done to load next PC
module mips_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_cnt,
    output logic [31:0] fetch_stall_cnt
`else
    output logic [31:0] pc_plus4
`endif
);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [31:0] PC_INIT = RESET_PC & ~32'd3;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic [31:0] br_off;

    // Request is decoded from the async-reset state register, so it drops with rst_n.
    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + br_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            pc          <= PC_INIT;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_RESET: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt     <= 32'd0;
            fetch_stall_cnt <= 32'd0;
        end else begin
            if (state == ST_EXEC && exec_done) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (state == ST_FETCH && !imem_ack) begin
                fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_ifetch.sv
// Directed bench for mips_ifetch: two instances share stimulus, differing only in RESET_PC.
module tb_mips_ifetch;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        branch;
    logic        jump;
    logic        zero;

    logic        a_req, b_req;
    logic [31:0] a_addr, b_addr;
    logic [31:0] a_instr, b_instr;
    logic [5:0]  a_op, b_op;
    logic        a_valid, b_valid;
    logic [31:0] a_pc, b_pc;
    logic [31:0] a_pc4, b_pc4;
`ifdef IFETCH_PERF_EN
    logic [31:0] a_ret, b_ret, a_stall, b_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;

    mips_ifetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .exec_done(exec_done), .branch(branch), .jump(jump), .zero(zero),
        .instr(a_instr), .op(a_op), .instr_valid(a_valid), .pc(a_pc),
`ifdef IFETCH_PERF_EN
        .pc_plus4(a_pc4), .retired_cnt(a_ret), .fetch_stall_cnt(a_stall)
`else
        .pc_plus4(a_pc4)
`endif
    );

    mips_ifetch #(.RESET_PC(32'h1000_000B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .exec_done(exec_done), .branch(branch), .jump(jump), .zero(zero),
        .instr(b_instr), .op(b_op), .instr_valid(b_valid), .pc(b_pc),
`ifdef IFETCH_PERF_EN
        .pc_plus4(b_pc4), .retired_cnt(b_ret), .fetch_stall_cnt(b_stall)
`else
        .pc_plus4(b_pc4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in FETCH; acks after 'waits' stall cycles.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int waits);
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req", 32'(a_req), 32'd1);
            check("fetch_addr", a_addr, exp_addr);
            check("fetch_valid", 32'(a_valid), 32'd0);
            imem_ack   = (i == waits);
            imem_rdata = word;
            step();
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("exec_valid", 32'(a_valid), 32'd1);
        check("exec_instr", a_instr, word);
        check("exec_op", 32'(a_op), 32'(word[31:26]));
        check("exec_req", 32'(a_req), 32'd0);
    endtask

    // Called at a negedge in EXEC; exec_done in the first EXEC cycle.
    task automatic do_exec(input logic br, input logic jp, input logic z, input logic [31:0] exp_pc);
        exec_done = 1'b1;
        branch    = br;
        jump      = jp;
        zero      = z;
        step();
        exec_done = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        zero      = 1'b0;
        exp_retired++;
        check("next_pc", a_pc, exp_pc);
        check("next_req", 32'(a_req), 32'd1);
        check("next_valid", 32'(a_valid), 32'd0);
    endtask

    localparam logic [31:0] W_J40   = {6'h02, 26'h40};
    localparam logic [31:0] W_J04   = {6'h02, 26'h4};
    localparam logic [31:0] W_BEQM1 = {6'h04, 5'd1, 5'd1, 16'hFFFC};
    localparam logic [31:0] W_BEQM2 = {6'h04, 5'd2, 5'd2, 16'hFFFE};
    localparam logic [31:0] W_ADD   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};

`ifdef IFETCH_PERF_EN
    logic [31:0] stall_before;
`endif

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exec_done  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        step();
        step();

        check("rst_pc", a_pc, 32'h0000_3000);
        check("rst_pc_b_masked", b_pc, 32'h1000_0008);
        check("rst_instr", a_instr, 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_req", 32'(a_req), 32'd0);
        check("rst_pc4", a_pc4, 32'h0000_3004);

        rst_n = 1'b1;
        step();

        // First fetch doubles as the jump-priority vector for both instances.
        do_fetch(32'h0000_3000, W_J40, 0);
        check("b_instr", b_instr, W_J40);
        // Ack during EXEC must not overwrite instr.
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack = 1'b0;
        check("exec_ack_ignored", a_instr, W_J40);
        check("exec_pc_stable", a_pc, 32'h0000_3000);
        do_exec(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        check("jump_prio_b", b_pc, 32'h1000_0100);

        // exec_done during FETCH is ignored.
        exec_done = 1'b1;
        jump      = 1'b1;
        step();
        exec_done = 1'b0;
        jump      = 1'b0;
        check("fetch_done_ignored", a_pc, 32'h0000_0100);
        do_fetch(32'h0000_0100, W_J04, 0);
        do_exec(1'b0, 1'b1, 1'b0, 32'h0000_0010);

        // beq not taken at 0x10, then 3-wait fetch at 0x14.
        do_fetch(32'h0000_0010, W_BEQM1, 0);
        do_exec(1'b1, 1'b0, 1'b0, 32'h0000_0014);
`ifdef IFETCH_PERF_EN
        stall_before = a_stall;
`endif
        do_fetch(32'h0000_0014, W_BEQM2, 3);
`ifdef IFETCH_PERF_EN
        check("stall_cnt_delta", a_stall - stall_before, 32'd3);
`endif
        do_exec(1'b1, 1'b0, 1'b1, 32'h0000_0010);

        // beq taken at 0x10 with offset -4 words.
        do_fetch(32'h0000_0010, W_BEQM1, 0);
        do_exec(1'b1, 1'b0, 1'b1, 32'h0000_0004);
        do_fetch(32'h0000_0004, W_BEQM2, 0);
        do_exec(1'b1, 1'b0, 1'b1, 32'h0000_0000);
        do_fetch(32'h0000_0000, W_BEQM2, 0);
        do_exec(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);

        // Sequential wrap; branch asserted without zero must not divert.
        do_fetch(32'hFFFF_FFFC, W_ADD, 0);
        check("wrap_pc4", a_pc4, 32'h0000_0000);
        do_exec(1'b1, 1'b0, 1'b0, 32'h0000_0000);
`ifdef IFETCH_PERF_EN
        check("retired_cnt", a_ret, 32'(exp_retired));
`endif

        // Asynchronous reset in the middle of a FETCH cycle, with an ack in flight.
        imem_ack   = 1'b1;
        imem_rdata = W_ADD;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(a_req), 32'd0);
        check("midrst_pc", a_pc, 32'h0000_3000);
        check("midrst_valid", 32'(a_valid), 32'd0);
        check("midrst_instr", a_instr, 32'd0);
`ifdef IFETCH_PERF_EN
        check("midrst_retired", a_ret, 32'd0);
        check("midrst_stall", a_stall, 32'd0);
`endif
        step();
        check("midrst_ack_discarded", a_instr, 32'd0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        step();
        do_fetch(32'h0000_3000, W_ADD, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
